// File: rtl/l2_lookup_sched.sv
// L2 tag lookup scheduler: arbitrates CPU vs forwarded lookups onto one datapath.
// Optional CPU fairness (starvation counter) when L2_LOOKUP_FAIR_EN is defined.
module l2_lookup_sched #(
    parameter int WAYS       = 8,
    parameter int STARVE_MAX = 4,
    localparam int WW        = $clog2(WAYS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req_valid,
    output logic          cpu_req_ready,
    input  logic          fwd_req_valid,
    output logic          fwd_req_ready,
    output logic          rd_arrays,
    output logic          lookup_en,
    output logic          lookup_mode,
    input  logic          tag_hit_in,
    input  logic [WW-1:0] way_hit_in,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_fwd,
    output logic          rsp_hit,
    output logic [WW-1:0] rsp_way,
    output logic          busy
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LOOK,
        CAPT,
        RESP
    } state_t;

    state_t state;
    logic   mode;
    logic   idle;
    logic   cpu_prio;
    logic   grant_fwd;
    logic   grant_cpu;

`ifdef L2_LOOKUP_FAIR_EN
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] starve;

    assign cpu_prio = cpu_req_valid && (starve == STARVE_LIM);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve <= 4'd0;
        end else if (grant_cpu) begin
            starve <= 4'd0;
        end else if (grant_fwd && cpu_req_valid
                     && starve != STARVE_LIM) begin
            starve <= starve + 4'd1;
        end
    end
`else
    assign cpu_prio = 1'b0;
`endif

    // Readies are combinational but forced low while reset is held.
    always_comb begin
        idle      = rst && (state == IDLE);
        grant_fwd = idle && fwd_req_valid && !cpu_prio;
        grant_cpu = idle && cpu_req_valid && !grant_fwd;
    end

    assign fwd_req_ready = grant_fwd;
    assign cpu_req_ready = grant_cpu;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            mode        <= 1'b0;
            rd_arrays   <= 1'b0;
            lookup_en   <= 1'b0;
            lookup_mode <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_fwd     <= 1'b0;
            rsp_hit     <= 1'b0;
            rsp_way     <= '0;
            busy        <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_fwd || grant_cpu) begin
                        mode      <= grant_fwd;
                        rd_arrays <= 1'b1;
                        busy      <= 1'b1;
                        state     <= READ;
                    end
                end
                READ: begin
                    rd_arrays   <= 1'b0;
                    lookup_en   <= 1'b1;
                    lookup_mode <= mode;
                    state       <= LOOK;
                end
                LOOK: begin
                    lookup_en   <= 1'b0;
                    lookup_mode <= 1'b0;
                    state       <= CAPT;
                end
                CAPT: begin
                    rsp_hit   <= tag_hit_in;
                    rsp_way   <= way_hit_in;
                    rsp_fwd   <= mode;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l2_lookup_sched.sv
// Directed bench for l2_lookup_sched.
// Fairness expectations follow L2_LOOKUP_FAIR_EN.
module tb_l2_lookup_sched;

    localparam int WW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cpu_req_valid = 1'b0;
    logic          cpu_req_ready;
    logic          fwd_req_valid = 1'b0;
    logic          fwd_req_ready;
    logic          rd_arrays;
    logic          lookup_en;
    logic          lookup_mode;
    logic          tag_hit_in = 1'b0;
    logic [WW-1:0] way_hit_in = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic          rsp_fwd;
    logic          rsp_hit;
    logic [WW-1:0] rsp_way;
    logic          busy;

    int total = 0;
    int bad   = 0;

    l2_lookup_sched #(.WAYS(8), .STARVE_MAX(4)) dut (
        .clk(clk),
        .rst(rst),
        .cpu_req_valid(cpu_req_valid),
        .cpu_req_ready(cpu_req_ready),
        .fwd_req_valid(fwd_req_valid),
        .fwd_req_ready(fwd_req_ready),
        .rd_arrays(rd_arrays),
        .lookup_en(lookup_en),
        .lookup_mode(lookup_mode),
        .tag_hit_in(tag_hit_in),
        .way_hit_in(way_hit_in),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_fwd(rsp_fwd),
        .rsp_hit(rsp_hit),
        .rsp_way(rsp_way),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [15:0] o;
        rst = 1'b0;
        cpu_req_valid = 1'b1;
        fwd_req_valid = 1'b1;
        cyc();
        cyc();
        o = {cpu_req_ready, fwd_req_ready, rd_arrays, lookup_en,
             lookup_mode, rsp_valid, rsp_fwd, rsp_hit, rsp_way,
             busy, 3'b000};
        total++;
        if (o !== 16'h0) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=0000", o);
        end
        cpu_req_valid = 1'b0;
        fwd_req_valid = 1'b0;
        rst = 1'b1;
        cyc();
        total++;
        if (busy !== 1'b0 || cpu_req_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle busy=%b rdy=%b exp=0,0",
                     busy, cpu_req_ready);
        end
    endtask

    task automatic test_single_cpu();
        tag_hit_in = 1'b1;
        way_hit_in = 3'd5;
        rsp_ready  = 1'b1;
        cpu_req_valid = 1'b1;
        #1;
        total++;
        if (cpu_req_ready !== 1'b1 || fwd_req_ready !== 1'b0) begin
            bad++;
            $display("FAIL single_accept cpu=%b fwd=%b exp=1,0",
                     cpu_req_ready, fwd_req_ready);
        end
        cyc();
        cpu_req_valid = 1'b0;
        total++;
        if (rd_arrays !== 1'b1 || lookup_en !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL single_read rd=%b le=%b busy=%b exp=1,0,1",
                     rd_arrays, lookup_en, busy);
        end
        cyc();
        total++;
        if (lookup_en !== 1'b1 || lookup_mode !== 1'b0
            || rd_arrays !== 1'b0) begin
            bad++;
            $display("FAIL single_look le=%b mode=%b rd=%b exp=1,0,0",
                     lookup_en, lookup_mode, rd_arrays);
        end
        cyc();
        total++;
        if (lookup_en !== 1'b0 || rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_capt le=%b rv=%b exp=0,0",
                     lookup_en, rsp_valid);
        end
        cyc();
        total++;
        if (rsp_valid !== 1'b1 || rsp_fwd !== 1'b0
            || rsp_hit !== 1'b1 || rsp_way !== 3'd5) begin
            bad++;
            $display("FAIL single_resp rv=%b fwd=%b hit=%b way=%0d exp=1,0,1,5",
                     rsp_valid, rsp_fwd, rsp_hit, rsp_way);
        end
        cyc();
        total++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL single_done rv=%b busy=%b exp=0,0",
                     rsp_valid, busy);
        end
    endtask

    task automatic test_both();
        tag_hit_in = 1'b0;
        way_hit_in = 3'd2;
        cpu_req_valid = 1'b1;
        fwd_req_valid = 1'b1;
        #1;
        total++;
        if (fwd_req_ready !== 1'b1 || cpu_req_ready !== 1'b0) begin
            bad++;
            $display("FAIL both_grant fwd=%b cpu=%b exp=1,0",
                     fwd_req_ready, cpu_req_ready);
        end
        cyc();
        fwd_req_valid = 1'b0;
        #1;
        total++;
        if (cpu_req_ready !== 1'b0 || fwd_req_ready !== 1'b0) begin
            bad++;
            $display("FAIL both_busy_rdy cpu=%b fwd=%b exp=0,0",
                     cpu_req_ready, fwd_req_ready);
        end
        cyc();
        total++;
        if (lookup_en !== 1'b1 || lookup_mode !== 1'b1) begin
            bad++;
            $display("FAIL both_mode le=%b mode=%b exp=1,1",
                     lookup_en, lookup_mode);
        end
        cyc();
        cyc();
        total++;
        if (rsp_valid !== 1'b1 || rsp_fwd !== 1'b1
            || rsp_hit !== 1'b0 || rsp_way !== 3'd2) begin
            bad++;
            $display("FAIL both_resp rv=%b fwd=%b hit=%b way=%0d exp=1,1,0,2",
                     rsp_valid, rsp_fwd, rsp_hit, rsp_way);
        end
        cyc();
        total++;
        if (cpu_req_ready !== 1'b1) begin
            bad++;
            $display("FAIL both_cpu_next cpu=%b exp=1", cpu_req_ready);
        end
        cyc();
        cpu_req_valid = 1'b0;
        cyc();
        cyc();
        cyc();
        total++;
        if (rsp_valid !== 1'b1 || rsp_fwd !== 1'b0) begin
            bad++;
            $display("FAIL both_cpu_resp rv=%b fwd=%b exp=1,0",
                     rsp_valid, rsp_fwd);
        end
        cyc();
    endtask

    task automatic test_stall();
        int errs;
        tag_hit_in = 1'b0;
        way_hit_in = 3'd3;
        rsp_ready  = 1'b0;
        cpu_req_valid = 1'b1;
        cyc();
        cpu_req_valid = 1'b0;
        cyc();
        cyc();
        cyc();
        cpu_req_valid = 1'b1;
        fwd_req_valid = 1'b1;
        errs = 0;
        for (int i = 0; i < 10; i++) begin
            tag_hit_in = i[0];
            way_hit_in = 3'(i);
            #1;
            if (rsp_valid !== 1'b1 || rsp_fwd !== 1'b0
                || rsp_hit !== 1'b0 || rsp_way !== 3'd3
                || cpu_req_ready !== 1'b0 || fwd_req_ready !== 1'b0
                || busy !== 1'b1)
                errs++;
            cyc();
        end
        total++;
        if (errs !== 0) begin
            bad++;
            $display("FAIL stall_hold bad_cycles=%0d exp=0", errs);
        end
        rsp_ready = 1'b1;
        cyc();
        total++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0
            || fwd_req_ready !== 1'b1) begin
            bad++;
            $display("FAIL stall_release rv=%b busy=%b fwdrdy=%b exp=0,0,1",
                     rsp_valid, busy, fwd_req_ready);
        end
        cpu_req_valid = 1'b0;
        fwd_req_valid = 1'b0;
        cyc();
    endtask

    task automatic test_back_to_back();
        int acc[$];
        int overlap;
        int rd_cnt;
        int le_cnt;
        overlap = 0;
        rd_cnt = 0;
        le_cnt = 0;
        rsp_ready = 1'b1;
        cpu_req_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            if (cpu_req_ready === 1'b1) acc.push_back(i);
            if (rd_arrays === 1'b1 && lookup_en === 1'b1) overlap++;
            if (rd_arrays === 1'b1) rd_cnt++;
            if (lookup_en === 1'b1) le_cnt++;
            cyc();
        end
        cpu_req_valid = 1'b0;
        total++;
        if (acc.size() !== 4) begin
            bad++;
            $display("FAIL b2b_count got=%0d exp=4", acc.size());
        end else begin
            total++;
            if (acc[1] - acc[0] !== 5 || acc[2] - acc[1] !== 5
                || acc[3] - acc[2] !== 5) begin
                bad++;
                $display("FAIL b2b_spacing got=%0d,%0d,%0d,%0d exp=0,5,10,15",
                         acc[0], acc[1], acc[2], acc[3]);
            end
        end
        total++;
        if (overlap !== 0 || rd_cnt !== 3 || le_cnt !== 3) begin
            bad++;
            $display("FAIL b2b_pulses ovl=%0d rd=%0d le=%0d exp=0,3,3",
                     overlap, rd_cnt, le_cnt);
        end
        for (int i = 0; i < 6; i++) cyc();
    endtask

    task automatic test_arb();
        logic g[$];
        int errs;
        logic e;
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        rsp_ready = 1'b1;
        cpu_req_valid = 1'b1;
        fwd_req_valid = 1'b1;
        errs = 0;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (fwd_req_ready === 1'b1 && cpu_req_ready === 1'b1) errs++;
            if (fwd_req_ready === 1'b1) g.push_back(1'b1);
            if (cpu_req_ready === 1'b1) g.push_back(1'b0);
            cyc();
        end
        cpu_req_valid = 1'b0;
        fwd_req_valid = 1'b0;
        total++;
        if (g.size() !== 10 || errs !== 0) begin
            bad++;
            $display("FAIL arb_count got=%0d dual=%0d exp=10,0",
                     g.size(), errs);
        end
        errs = 0;
        for (int i = 0; i < g.size(); i++) begin
`ifdef L2_LOOKUP_FAIR_EN
            e = (i % 5 == 4) ? 1'b0 : 1'b1;
`else
            e = 1'b1;
`endif
            if (g[i] !== e) errs++;
        end
        total++;
        if (errs !== 0) begin
            bad++;
            $display("FAIL arb_order wrong_grants=%0d exp=0", errs);
        end
        for (int i = 0; i < 6; i++) cyc();
    endtask

    task automatic test_reset_mid();
        int seen;
        tag_hit_in = 1'b1;
        way_hit_in = 3'd7;
        rsp_ready = 1'b1;
        cpu_req_valid = 1'b1;
        cyc();
        cpu_req_valid = 1'b0;
        cyc();
        total++;
        if (lookup_en !== 1'b1) begin
            bad++;
            $display("FAIL mid_look le=%b exp=1", lookup_en);
        end
        rst = 1'b0;
        #1;
        total++;
        if (lookup_en !== 1'b0 || busy !== 1'b0 || rd_arrays !== 1'b0
            || rsp_valid !== 1'b0 || lookup_mode !== 1'b0) begin
            bad++;
            $display("FAIL mid_rst_async le=%b busy=%b rd=%b rv=%b exp=0,0,0,0",
                     lookup_en, busy, rd_arrays, rsp_valid);
        end
        cyc();
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (rsp_valid === 1'b1 || busy === 1'b1) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL mid_no_rsp got=%0d exp=0", seen);
        end
        way_hit_in = 3'd6;
        cpu_req_valid = 1'b1;
        #1;
        total++;
        if (cpu_req_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_new_accept rdy=%b exp=1", cpu_req_ready);
        end
        cyc();
        cpu_req_valid = 1'b0;
        total++;
        if (rd_arrays !== 1'b1) begin
            bad++;
            $display("FAIL mid_new_rd rd=%b exp=1", rd_arrays);
        end
        cyc();
        cyc();
        cyc();
        total++;
        if (rsp_valid !== 1'b1 || rsp_way !== 3'd6 || rsp_hit !== 1'b1) begin
            bad++;
            $display("FAIL mid_new_rsp rv=%b way=%0d hit=%b exp=1,6,1",
                     rsp_valid, rsp_way, rsp_hit);
        end
        cyc();
    endtask

    initial begin
        test_reset();
        test_single_cpu();
        test_both();
        test_stall();
        test_back_to_back();
        test_arb();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
